// File: rtl/avalon_gen_pkg.sv
// Shared constants, register map and FSM encoding for the Avalon-ST frame generator.
package avalon_gen_pkg;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_NUM_PKTS = 1;
  localparam int ADDR_PKT_LEN  = 2;
  localparam int ADDR_DST_LO   = 3;
  localparam int ADDR_DST_HI   = 4;
  localparam int ADDR_SRC_LO   = 5;
  localparam int ADDR_SRC_HI   = 6;
  localparam int ADDR_TX_CNT   = 7;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 1;

  localparam logic [15:0] ETHERTYPE_TEST = 16'h88B5;
  localparam logic [13:0] PKT_LEN_RST    = 14'd64;

  localparam int MIN_LEN_DEF = 24;
  localparam int MAX_LEN_DEF = 9600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_GAP
  } gen_state_e;

endpackage

// File: rtl/avalon_gen_regs.sv
// Avalon-MM register file: address decode, configuration registers, registered readdata.
module avalon_gen_regs
  import avalon_gen_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avalon_mm_address,
  input  logic              avalon_mm_write,
  input  logic [31:0]       avalon_mm_writedata,
  input  logic              avalon_mm_read,
  output logic [31:0]       avalon_mm_readdata,
  input  logic              busy,
  input  logic              done,
  input  logic [31:0]       tx_pkt_cnt,
  output logic              start_pulse,
  output logic              stop_pulse,
  output logic [31:0]       num_pkts,
  output logic [13:0]       pkt_len,
  output logic [47:0]       dst_mac,
  output logic [47:0]       src_mac
);

  logic [31:0] num_pkts_q, num_pkts_d;
  logic [13:0] pkt_len_q, pkt_len_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ctrl_wr;

  // Stop wins over a simultaneous start, so such a write never launches a frame.
  assign ctrl_wr     = avalon_mm_write && (avalon_mm_address == ADDR_W'(ADDR_CTRL));
  assign start_pulse = ctrl_wr && avalon_mm_writedata[CTRL_START] && !avalon_mm_writedata[CTRL_STOP];
  assign stop_pulse  = ctrl_wr && avalon_mm_writedata[CTRL_STOP];

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    num_pkts_d = num_pkts_q;
    pkt_len_d  = pkt_len_q;
    dst_mac_d  = dst_mac_q;
    src_mac_d  = src_mac_q;
    rdata_d    = '0;
    if (avalon_mm_write) begin
      case (avalon_mm_address)
        ADDR_W'(ADDR_NUM_PKTS): num_pkts_d        = avalon_mm_writedata;
        ADDR_W'(ADDR_PKT_LEN):  pkt_len_d         = avalon_mm_writedata[13:0];
        ADDR_W'(ADDR_DST_LO):   dst_mac_d[31:0]   = avalon_mm_writedata;
        ADDR_W'(ADDR_DST_HI):   dst_mac_d[47:32]  = avalon_mm_writedata[15:0];
        ADDR_W'(ADDR_SRC_LO):   src_mac_d[31:0]   = avalon_mm_writedata;
        ADDR_W'(ADDR_SRC_HI):   src_mac_d[47:32]  = avalon_mm_writedata[15:0];
        default: ;
      endcase
    end
    if (avalon_mm_read) begin
      case (avalon_mm_address)
        ADDR_W'(ADDR_CTRL):     rdata_d = {30'd0, done, busy};
        ADDR_W'(ADDR_NUM_PKTS): rdata_d = num_pkts_q;
        ADDR_W'(ADDR_PKT_LEN):  rdata_d = {18'd0, pkt_len_q};
        ADDR_W'(ADDR_DST_LO):   rdata_d = dst_mac_q[31:0];
        ADDR_W'(ADDR_DST_HI):   rdata_d = {16'd0, dst_mac_q[47:32]};
        ADDR_W'(ADDR_SRC_LO):   rdata_d = src_mac_q[31:0];
        ADDR_W'(ADDR_SRC_HI):   rdata_d = {16'd0, src_mac_q[47:32]};
        ADDR_W'(ADDR_TX_CNT):   rdata_d = tx_pkt_cnt;
        default: ;
      endcase
    end
  end

  // NOTE: these are a handful of config flops, not a RAM, so each gets an explicit reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_pkts_q <= '0;
      pkt_len_q  <= PKT_LEN_RST;
      dst_mac_q  <= '0;
      src_mac_q  <= '0;
      rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its neighbours.
      num_pkts_q <= num_pkts_d;
      pkt_len_q  <= pkt_len_d;
      dst_mac_q  <= dst_mac_d;
      src_mac_q  <= src_mac_d;
      rdata_q    <= rdata_d;
    end
  end

  assign avalon_mm_readdata = rdata_q;
  assign num_pkts           = num_pkts_q;
  assign pkt_len            = pkt_len_q;
  assign dst_mac            = dst_mac_q;
  assign src_mac            = src_mac_q;

endmodule

// File: rtl/avalon_st_pkt_gen.sv
// 64-bit Avalon-ST Ethernet test-frame generator with an Avalon-MM control slave.
module avalon_st_pkt_gen
  import avalon_gen_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int IPG_CYCLES = 4,
  parameter int MIN_LEN    = MIN_LEN_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avalon_mm_address,
  input  logic              avalon_mm_write,
  input  logic [31:0]       avalon_mm_writedata,
  input  logic              avalon_mm_read,
  output logic [31:0]       avalon_mm_readdata,
  output logic [63:0]       avalon_st_tx_data,
  output logic              avalon_st_tx_valid,
  output logic              avalon_st_tx_sop,
  output logic              avalon_st_tx_eop,
  output logic [2:0]        avalon_st_tx_empty,
  output logic              avalon_st_tx_error,
  input  logic              avalon_st_tx_ready,
  output logic              gen_active,
  output logic              gen_done
);

  logic        start_pulse, stop_pulse;
  logic [31:0] num_pkts;
  logic [13:0] pkt_len;
  logic [47:0] dst_mac, src_mac;

  gen_state_e  state_q, state_d;
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [2:0]  empty_q, empty_d;
  logic        active_q, active_d, done_q, done_d, stop_pend_q, stop_pend_d;
  logic [15:0] seq_q, seq_d, beat_q, beat_d, gap_q, gap_d;
  logic [13:0] len_q, len_d;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic [31:0] cnt_q, cnt_d;

  logic        xfer, load, new_frame, last;
  logic [15:0] ld_idx;
  logic [13:0] frame_len, frame_beats;
  logic [47:0] frame_dst, frame_src;
  logic [63:0] word;
  logic [2:0]  ld_empty;

  avalon_gen_regs #(.ADDR_W(ADDR_W)) u_regs (
    .clk                 (clk),
    .reset               (reset),
    .avalon_mm_address   (avalon_mm_address),
    .avalon_mm_write     (avalon_mm_write),
    .avalon_mm_writedata (avalon_mm_writedata),
    .avalon_mm_read      (avalon_mm_read),
    .avalon_mm_readdata  (avalon_mm_readdata),
    .busy                (active_q),
    .done                (done_q),
    .tx_pkt_cnt          (cnt_q),
    .start_pulse         (start_pulse),
    .stop_pulse          (stop_pulse),
    .num_pkts            (num_pkts),
    .pkt_len             (pkt_len),
    .dst_mac             (dst_mac),
    .src_mac             (src_mac)
  );

  function automatic logic [13:0] clamp_len(input logic [13:0] l);
    if (l < 14'(MIN_LEN)) return 14'(MIN_LEN);
    if (l > 14'(MAX_LEN)) return 14'(MAX_LEN);
    return l;
  endfunction

  function automatic logic [63:0] beat_word(input logic [15:0] idx, input logic [15:0] seq,
                                            input logic [47:0] dst, input logic [47:0] src);
    if (idx == 16'd0) return {dst, src[47:32]};
    if (idx == 16'd1) return {src[31:0], ETHERTYPE_TEST, seq};
    return {seq, idx, seq, idx};
  endfunction

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    empty_d     = empty_q;
    active_d    = active_q;
    done_d      = done_q;
    stop_pend_d = stop_pend_q;
    seq_d       = seq_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    len_d       = len_q;
    dst_d       = dst_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    xfer        = valid_q && avalon_st_tx_ready;
    load        = 1'b0;
    new_frame   = 1'b0;
    ld_idx      = beat_q;

    if (stop_pulse && state_q != ST_IDLE) stop_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: if (start_pulse) begin
        cnt_d       = '0;
        done_d      = 1'b0;
        active_d    = 1'b1;
        seq_d       = '0;
        stop_pend_d = 1'b0;
        state_d     = ST_HDR0;
        load        = 1'b1;
        new_frame   = 1'b1;
        ld_idx      = 16'd0;
      end
      ST_HDR0: if (xfer) begin
        state_d = ST_HDR1;
        load    = 1'b1;
        ld_idx  = 16'd1;
      end
      ST_HDR1: if (xfer) begin
        state_d = ST_PAYLOAD;
        load    = 1'b1;
        ld_idx  = 16'd2;
      end
      ST_PAYLOAD: if (xfer) begin
        if (eop_q) begin
          state_d = ST_GAP;
          valid_d = 1'b0;
          eop_d   = 1'b0;
          empty_d = '0;
          data_d  = '0;
          gap_d   = 16'(IPG_CYCLES - 1);
          if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        end else begin
          load   = 1'b1;
          ld_idx = beat_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 16'd1;
        end else if (stop_pend_q || (num_pkts != '0 && cnt_q >= num_pkts)) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          active_d    = 1'b0;
          stop_pend_d = 1'b0;
        end else begin
          state_d   = ST_HDR0;
          seq_d     = seq_q + 16'd1;
          load      = 1'b1;
          new_frame = 1'b1;
          ld_idx    = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame config is snapshotted when beat 0 is loaded; mid-frame MM writes wait for the next SOP.
    frame_len   = new_frame ? clamp_len(pkt_len) : len_q;
    frame_dst   = new_frame ? dst_mac : dst_q;
    frame_src   = new_frame ? src_mac : src_q;
    frame_beats = (frame_len + 14'd7) >> 3;
    last        = (ld_idx == {2'b00, frame_beats - 14'd1});
    ld_empty    = last ? 3'(3'd0 - frame_len[2:0]) : 3'd0;
    word        = beat_word(ld_idx, seq_d, frame_dst, frame_src);

    if (load) begin
      len_d   = frame_len;
      dst_d   = frame_dst;
      src_d   = frame_src;
      beat_d  = ld_idx;
      valid_d = 1'b1;
      sop_d   = (ld_idx == 16'd0);
      eop_d   = last;
      empty_d = ld_empty;
      data_d  = word & (~64'd0 << {ld_empty, 3'b000});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      empty_q     <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      seq_q       <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      len_q       <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      empty_q     <= empty_d;
      active_q    <= active_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      seq_q       <= seq_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      len_q       <= len_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
    end
  end

  assign avalon_st_tx_data  = data_q;
  assign avalon_st_tx_valid = valid_q;
  assign avalon_st_tx_sop   = sop_q;
  assign avalon_st_tx_eop   = eop_q;
  assign avalon_st_tx_empty = empty_q;
  assign avalon_st_tx_error = 1'b0;
  assign gen_active         = active_q;
  assign gen_done           = done_q;

endmodule

// File: tb/tb_avalon_st_pkt_gen.sv
// Directed self-checking bench for avalon_st_pkt_gen: frame contents, IPG, backpressure, stop, clamping, reset.
module tb_avalon_st_pkt_gen;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  mm_addr = '0;
  logic        mm_write = 1'b0;
  logic [31:0] mm_wdata = '0;
  logic        mm_read = 1'b0;
  logic [31:0] mm_rdata;
  logic [63:0] tx_data;
  logic        tx_valid, tx_sop, tx_eop, tx_error;
  logic [2:0]  tx_empty;
  logic        tx_ready = 1'b1;
  logic        gen_active, gen_done;

  beat_t       cap[$];
  beat_t       snap;
  bit          rand_ready = 1'b0;
  bit          in_frame = 1'b0;
  bit          prev_stall = 1'b0;
  int          cyc = 0;
  int          stall_err = 0;
  int          bubble_err = 0;
  int          stalls_seen = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] rd;
  int          base;

  avalon_st_pkt_gen dut (
    .clk                 (clk),
    .reset               (reset),
    .avalon_mm_address   (mm_addr),
    .avalon_mm_write     (mm_write),
    .avalon_mm_writedata (mm_wdata),
    .avalon_mm_read      (mm_read),
    .avalon_mm_readdata  (mm_rdata),
    .avalon_st_tx_data   (tx_data),
    .avalon_st_tx_valid  (tx_valid),
    .avalon_st_tx_sop    (tx_sop),
    .avalon_st_tx_eop    (tx_eop),
    .avalon_st_tx_empty  (tx_empty),
    .avalon_st_tx_error  (tx_error),
    .avalon_st_tx_ready  (tx_ready),
    .gen_active          (gen_active),
    .gen_done            (gen_done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Sink-side monitor: captures transfers and flags stall instability or in-frame bubbles.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        in_frame   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!tx_valid || tx_data !== snap.data || tx_sop !== snap.sop ||
                           tx_eop !== snap.eop || tx_empty !== snap.empty))
          stall_err++;
        if (in_frame && !tx_valid) bubble_err++;
        prev_stall = tx_valid && !tx_ready;
        if (prev_stall) stalls_seen++;
        snap = '{tx_data, tx_sop, tx_eop, tx_empty, cyc};
        if (tx_valid && tx_ready) begin
          cap.push_back('{tx_data, tx_sop, tx_eop, tx_empty, cyc});
          if (tx_sop) in_frame = 1'b1;
          if (tx_eop) in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic beat_t at(input int i);
    beat_t b = '{64'd0, 1'b0, 1'b0, 3'd0, 0};
    if (i >= 0 && i < cap.size()) b = cap[i];
    return b;
  endfunction

  function automatic int count_sop();
    int n = 0;
    foreach (cap[i]) if (cap[i].sop) n++;
    return n;
  endfunction

  function automatic int count_eop();
    int n = 0;
    foreach (cap[i]) if (cap[i].eop) n++;
    return n;
  endfunction

  task automatic mm_write_t(input logic [9:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    mm_addr = a; mm_wdata = d; mm_write = 1'b1;
    @(posedge clk); #1;
    mm_write = 1'b0;
  endtask

  task automatic mm_read_t(input logic [9:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    mm_addr = a; mm_read = 1'b1;
    @(posedge clk); #1;
    mm_read = 1'b0;
    d = mm_rdata;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !gen_done; i++) @(negedge clk);
    check(tag, gen_done, 1'b1);
  endtask

  task automatic set_macs();
    mm_write_t(10'd3, 32'h22334455);
    mm_write_t(10'd4, 32'h00000011);
    mm_write_t(10'd5, 32'h8899AABB);
    mm_write_t(10'd6, 32'h00006677);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_sop_eop", {tx_sop, tx_eop}, 2'b00);
    check("rst_active_done", {gen_active, gen_done}, 2'b00);
    mm_read_t(10'd2, rd); check("rst_pkt_len", rd, 32'd64);
    mm_read_t(10'd0, rd); check("rst_ctrl", rd, 32'd0);
    mm_read_t(10'd7, rd); check("rst_tx_cnt", rd, 32'd0);
    mm_read_t(10'd1, rd); check("rst_num_pkts", rd, 32'd0);

    // 64-byte single frame
    set_macs();
    mm_write_t(10'd1, 32'd1);
    cap.delete();
    mm_write_t(10'd0, 32'd1);
    wait_done("t1_done", 200);
    check("t1_beats", cap.size(), 8);
    check("t1_b0", at(0).data, 64'h0011223344556677);
    check("t1_b0_sop", at(0).sop, 1'b1);
    check("t1_b1", at(1).data, 64'h8899AABB88B50000);
    check("t1_b2", at(2).data, 64'h0000000200000002);
    check("t1_b7", at(7).data, 64'h0000000700000007);
    check("t1_b7_eop_empty", {at(7).eop, at(7).empty}, 4'b1_000);
    mm_read_t(10'd7, rd); check("t1_tx_cnt", rd, 32'd1);
    mm_read_t(10'd0, rd); check("t1_ctrl", rd, 32'd2);

    // Two 65-byte frames with IPG
    mm_write_t(10'd2, 32'd65);
    mm_write_t(10'd1, 32'd2);
    cap.delete();
    mm_write_t(10'd0, 32'd1);
    wait_done("t2_done", 300);
    check("t2_beats", cap.size(), 18);
    check("t2_f0_eop_empty", {at(8).eop, at(8).empty}, 4'b1_111);
    check("t2_f0_eop_pad", at(8).data & 64'h00FFFFFFFFFFFFFF, 64'd0);
    check("t2_f1_sop", at(9).sop, 1'b1);
    check("t2_ipg", at(9).cyc - at(8).cyc - 1, 4);
    check("t2_f1_b1_seq", at(10).data, 64'h8899AABB88B50001);
    check("t2_f1_b2", at(11).data, 64'h0001000200010002);
    check("t2_f1_eop_empty", {at(17).eop, at(17).empty}, 4'b1_111);
    mm_read_t(10'd7, rd); check("t2_tx_cnt", rd, 32'd2);

    // 1518-byte frame under random backpressure
    mm_write_t(10'd2, 32'd1518);
    mm_write_t(10'd1, 32'd1);
    stall_err = 0; bubble_err = 0; stalls_seen = 0;
    cap.delete();
    rand_ready = 1'b1;
    mm_write_t(10'd0, 32'd1);
    wait_done("t3_done", 3000);
    rand_ready = 1'b0;
    check("t3_beats", cap.size(), 190);
    check("t3_eop_empty", {at(189).eop, at(189).empty}, 4'b1_010);
    check("t3_last", at(189).data, 64'h000000BD00000000);
    check("t3_stall_stable", stall_err, 0);
    check("t3_no_bubbles", bubble_err, 0);
    check("t3_stalls_seen", stalls_seen > 0, 1'b1);

    // Continuous mode, stop during frame 3
    mm_write_t(10'd2, 32'd64);
    mm_write_t(10'd1, 32'd0);
    cap.delete();
    mm_write_t(10'd0, 32'd1);
    for (int i = 0; i < 500 && count_sop() < 3; i++) @(negedge clk);
    check("t4_reach_f3", count_sop(), 3);
    mm_write_t(10'd0, 32'd2);
    wait_done("t4_done", 500);
    base = cap.size();
    repeat (30) @(negedge clk);
    check("t4_frames", count_eop(), 3);
    check("t4_no_f4", cap.size(), base);
    mm_read_t(10'd7, rd); check("t4_tx_cnt", rd, 32'd3);
    check("t4_done_flag", gen_done, 1'b1);

    // Length clamping
    mm_write_t(10'd2, 32'd10);
    mm_write_t(10'd1, 32'd1);
    cap.delete();
    mm_write_t(10'd0, 32'd1);
    wait_done("t5a_done", 100);
    check("t5a_beats", cap.size(), 3);
    check("t5a_eop_empty", {at(2).eop, at(2).empty}, 4'b1_000);
    check("t5a_last", at(2).data, 64'h0000000200000002);
    mm_write_t(10'd2, 32'd10000);
    cap.delete();
    mm_write_t(10'd0, 32'd1);
    wait_done("t5b_done", 3000);
    check("t5b_beats", cap.size(), 1200);
    check("t5b_eop_empty", {at(1199).eop, at(1199).empty}, 4'b1_000);
    check("t5b_last", at(1199).data, 64'h000004AF000004AF);

    // Reset mid-payload of frame 2, then a clean restart
    mm_write_t(10'd2, 32'd64);
    mm_write_t(10'd1, 32'd0);
    cap.delete();
    mm_write_t(10'd0, 32'd1);
    for (int i = 0; i < 300 && cap.size() < 12; i++) @(negedge clk);
    check("t6_reach_payload", cap.size() >= 12, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_st", {tx_valid, tx_sop, tx_eop}, 3'b000);
    check("t6_rst_active", gen_active, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    mm_read_t(10'd2, rd); check("t6_pkt_len", rd, 32'd64);
    mm_read_t(10'd3, rd); check("t6_dst_lo", rd, 32'd0);
    mm_read_t(10'd7, rd); check("t6_tx_cnt", rd, 32'd0);
    set_macs();
    mm_write_t(10'd1, 32'd1);
    cap.delete();
    mm_write_t(10'd0, 32'd1);
    wait_done("t6_done", 200);
    check("t6_beats", cap.size(), 8);
    check("t6_b1_seq0", at(1).data, 64'h8899AABB88B50000);
    check("t6_b2", at(2).data, 64'h0000000200000002);
    check("t6_error_low", tx_error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
